// File: rtl/l2_norm_pkg.sv
// Shared constants, FSM encoding and the per-beat squares-sum for the L2-norm engine.
package l2_norm_pkg;

  localparam int LANES  = 8;
  localparam int EW     = 8;
  localparam int ACC_W  = 32;
  localparam int FRAC   = 8;
  // The root of (N << 2*FRAC) carries FRAC fractional bits.
  localparam int M_W    = ACC_W + 2 * FRAC;
  localparam int ROOT_W = M_W / 2;

  typedef enum logic [1:0] {ACCUM, SQRT, HOLD} l2_state_e;

  function automatic logic [ACC_W-1:0] sq_sum8(input logic [LANES*EW-1:0] d);
    logic [ACC_W-1:0]        s;
    logic signed [EW-1:0]    e;
    logic signed [2*EW-1:0]  p;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      e = d[i*EW +: EW];
      p = (2*EW)'(e) * (2*EW)'(e);
      s = s + ACC_W'(unsigned'(p));
    end
    return s;
  endfunction

endpackage

// File: rtl/l2_norm_engine_if.sv
// Input beat stream and output result stream of the L2-norm engine.
interface l2_norm_engine_if;

  logic [l2_norm_pkg::LANES*l2_norm_pkg::EW-1:0] in_data;
  logic                                          in_valid;
  logic                                          in_last;
  logic                                          in_ready;
  logic [l2_norm_pkg::ACC_W-1:0]                 out_data;
  logic                                          out_valid;
  logic                                          out_ready;
  logic                                          out_last;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/l2_isqrt_newton.sv
// Integer sqrt of (operand << 2*FRAC) by Newton iteration, one restoring-divider
// quotient bit per cycle.
module l2_isqrt_newton
  import l2_norm_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ACC_W-1:0]  operand,
  output logic              busy,
  output logic              done,
  output logic [ROOT_W-1:0] root
);

  localparam int X_W   = ROOT_W + 1;
  localparam int Q_W   = ROOT_W + 2;
  localparam int CNT_W = $clog2(Q_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_UPD} sq_state_e;

  sq_state_e         st_q, st_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [X_W-1:0]    x_q, x_d, rem_q, rem_d;
  logic [Q_W-1:0]    quo_q, quo_d, dvd_q, dvd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [ROOT_W-1:0] root_q, root_d;

  logic [M_W-1:0]    m_new;
  logic [X_W:0]      r2;
  logic [Q_W:0]      x_sum;
  logic [Q_W-1:0]    x_new;

  // 2^ceil(bitlen(M)/2); bitlen(M) = bitlen(N) + 2*FRAC for nonzero N.
  function automatic logic [X_W-1:0] x_init(input logic [ACC_W-1:0] n);
    int bl;
    bl = 0;
    for (int i = 0; i < ACC_W; i++) if (n[i]) bl = i + 1;
    return X_W'(1) << (FRAC + (bl + 1) / 2);
  endfunction

  assign m_new = {operand, (2*FRAC)'(0)};
  assign r2    = {rem_q, dvd_q[Q_W-1]};
  assign x_sum = (Q_W+1)'(quo_q) + (Q_W+1)'(x_q);
  assign x_new = x_sum[Q_W:1];

  // Every iterate stays >= floor(sqrt(M)), so M/x < 2^Q_W: the top dividend
  // bits can be preloaded as the remainder and only Q_W steps are needed.
  always_comb begin
    st_d   = st_q;
    m_d    = m_q;
    x_d    = x_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvd_d  = dvd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    root_d = root_q;
    case (st_q)
      S_IDLE: if (start) begin
        if (operand == '0) begin
          root_d = '0;
          done_d = 1'b1;
        end else begin
          m_d   = m_new;
          x_d   = x_init(operand);
          rem_d = X_W'(m_new[M_W-1:Q_W]);
          dvd_d = m_new[Q_W-1:0];
          quo_d = '0;
          cnt_d = CNT_W'(Q_W);
          st_d  = S_DIV;
        end
      end
      S_DIV: begin
        if (r2 >= {1'b0, x_q}) begin
          rem_d = X_W'(r2 - {1'b0, x_q});
          quo_d = {quo_q[Q_W-2:0], 1'b1};
        end else begin
          rem_d = r2[X_W-1:0];
          quo_d = {quo_q[Q_W-2:0], 1'b0};
        end
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) st_d = S_UPD;
      end
      S_UPD: begin
        if (x_new >= Q_W'(x_q)) begin
          root_d = x_q[ROOT_W-1:0];
          done_d = 1'b1;
          st_d   = S_IDLE;
        end else begin
          x_d   = x_new[X_W-1:0];
          rem_d = X_W'(m_q[M_W-1:Q_W]);
          dvd_d = m_q[Q_W-1:0];
          quo_d = '0;
          cnt_d = CNT_W'(Q_W);
          st_d  = S_DIV;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q   <= S_IDLE;
      m_q    <= '0;
      x_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      root_q <= '0;
    end else begin
      st_q   <= st_d;
      m_q    <= m_d;
      x_q    <= x_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvd_q  <= dvd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      root_q <= root_d;
    end
  end

  assign busy = (st_q != S_IDLE);
  assign done = done_q;
  assign root = root_q;

endmodule

// File: rtl/l2_norm_engine.sv
// Streaming L2-norm core: accumulate per-beat squares-sums, then emit the
// Q24.8 square root of the vector total.
module l2_norm_engine
  import l2_norm_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  l2_norm_engine_if.slave  bus
);

  l2_state_e          st_q, st_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [ACC_W-1:0]   beat_sum, acc_sum;
  logic               xfer, sq_start, sq_busy, sq_done;
  logic [ROOT_W-1:0]  sq_root;

  assign beat_sum = sq_sum8(bus.in_data);
  assign acc_sum  = acc_q + beat_sum;
  assign xfer     = bus.in_valid && (st_q == ACCUM);
  // The root unit takes the final sum directly so it starts on the last-beat edge.
  assign sq_start = xfer && bus.in_last && !sq_busy;

  l2_isqrt_newton u_isqrt (
    .clock   (clock),
    .reset   (reset),
    .start   (sq_start),
    .operand (acc_sum),
    .busy    (sq_busy),
    .done    (sq_done),
    .root    (sq_root)
  );

  always_comb begin
    st_d        = st_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (st_q)
      ACCUM: if (xfer) begin
        if (bus.in_last) begin
          acc_d = '0;
          st_d  = SQRT;
        end else begin
          acc_d = acc_sum;
        end
      end
      SQRT: if (sq_done) begin
        out_data_d  = {(ACC_W-ROOT_W)'(0), sq_root};
        out_valid_d = 1'b1;
        st_d        = HOLD;
      end
      HOLD: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        st_d        = ACCUM;
      end
      default: st_d = ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= ACCUM;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (st_q == ACCUM);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_valid_q;

endmodule

// File: tb/tb_l2_norm_engine.sv
// Random and directed vectors against an arithmetic reference of the L2 norm.
module tb_l2_norm_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_norm_engine_if bus();

  l2_norm_engine dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int     n_chk = 0;
  int     n_err = 0;
  longint acc_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_beat(input logic [63:0] d);
    longint s;
    logic signed [7:0] e;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      e = d[8*i +: 8];
      s += longint'(e) * longint'(e);
    end
    return s;
  endfunction

  // Largest r with r*r <= N*2^16, by bisection.
  function automatic longint ref_root(input longint n);
    longint m, lo, hi, mid;
    m  = n << 16;
    lo = 0;
    hi = 64'd1 << 24;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= m) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    int w;
    w = 0;
    while (!bus.in_ready && w < 1000) begin
      tick();
      w++;
    end
    chk("in_ready_before_beat", bus.in_ready, 1);
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    acc_m = (acc_m + ref_beat(d)) & 64'hFFFF_FFFF;
  endtask

  task automatic expect_result(input string tag, input int hold, output int lat);
    longint exp;
    exp   = ref_root(acc_m);
    acc_m = 0;
    lat   = 0;
    while (!bus.out_valid && lat < 500) begin
      tick();
      lat++;
    end
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_latency_le_400"}, lat <= 400, 1);
    chk({tag, "_data"}, bus.out_data, exp);
    chk({tag, "_last"}, bus.out_last, 1);
    chk({tag, "_in_ready_busy"}, bus.in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, "_hold_data"}, bus.out_data, exp);
      chk({tag, "_hold_valid"}, bus.out_valid, 1);
      chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    int lat;
    int nb;
    logic [63:0] d;
    logic seen;

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    send(64'h0303030303030303, 1'b1);
    expect_result("lanes3", 0, lat);

    send(64'h8080808080808080, 1'b1);
    expect_result("lanes_m128", 0, lat);

    // Two-beat vector with an in_last-without-valid gap that must be ignored.
    send(64'h0000000000000004, 1'b0);
    bus.in_last = 1'b1;
    repeat (2) tick();
    bus.in_last = 1'b0;
    chk("last_no_valid_out_valid", bus.out_valid, 0);
    chk("last_no_valid_in_ready", bus.in_ready, 1);
    send(64'h0000000000000003, 1'b1);
    expect_result("two_beat", 0, lat);
    send(64'h0000000000000001, 1'b1);
    expect_result("acc_cleared", 0, lat);

    send(64'h0, 1'b1);
    expect_result("zero", 0, lat);
    chk("zero_latency_le_3", lat <= 3, 1);

    d = {$urandom, $urandom};
    send(d, 1'b1);
    expect_result("hold20", 20, lat);

    // Abort a long root computation with reset.
    send(64'h7F7F7F7F7F7F7F7F, 1'b1);
    repeat (5) tick();
    chk("sqrt_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_m = 0;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (300) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);
    send(64'h0000000000000002, 1'b1);
    expect_result("after_abort", 0, lat);

    for (int v = 0; v < 25; v++) begin
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        d = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) d[8*$urandom_range(0, 7) +: 8] = 8'h80;
        if ($urandom_range(0, 5) == 0) d = '0;
        send(d, b == nb - 1);
      end
      expect_result("rand", $urandom_range(0, 3), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
